// File: rtl/gauss_uart_sched.sv
// Streams a Gaussian-filtered frame from result memory to a UART transmitter
// as SYNC_BYTE, pixels in raster order, then an 8-bit modulo-256 checksum.
module gauss_uart_sched #(
    parameter int          IMG_W     = 8,
    parameter int          IMG_H     = 8,
    parameter int          ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              filt_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_SYNC    = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_PIX     = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        pix_q, pix_d;
    logic              xfer;

    assign tx_valid   = (state_q == S_SYNC) || (state_q == S_PIX) ||
                        (state_q == S_CSUM);
    assign xfer       = tx_valid && tx_ready;
    assign mem_rd_en  = (state_q == S_RD);
    assign mem_addr   = addr_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

    always_comb begin
        case (state_q)
            S_SYNC:  tx_data = SYNC_BYTE;
            S_PIX:   tx_data = pix_q;
            S_CSUM:  tx_data = csum_q;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        pix_d   = pix_q;
        // Abort wins over any handshake completing on the same edge.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                        csum_d  = 8'h00;
                    end
                end
                S_WAIT: begin
                    if (filt_done) state_d = S_SYNC;
                end
                S_SYNC: begin
                    if (xfer) begin
                        state_d = S_RD;
                        addr_d  = idx_q;
                    end
                end
                S_RD: begin
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    pix_d   = mem_rd_data;
                    state_d = S_PIX;
                end
                S_PIX: begin
                    if (xfer) begin
                        csum_d = csum_q + pix_q;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CSUM;
                        end else begin
                            idx_d   = idx_q + ONE;
                            addr_d  = idx_q + ONE;
                            state_d = S_RD;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            csum_q  <= 8'h00;
            pix_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            pix_q   <= pix_d;
        end
    end

endmodule

// File: tb/tb_gauss_uart_sched.sv
// Directed bench for gauss_uart_sched on a 2x2 image with a
// one-cycle-latency memory model and a byte logger on the tx port.
module tb_gauss_uart_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       filt_done = 1'b0;
    logic       mem_rd_en;
    logic [1:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [4];
    logic [7:0] log_q [$];
    int         tlog [$];
    int         cyc = 0;
    int         fd_cnt = 0;
    int         tests = 0;
    int         fails = 0;

    gauss_uart_sched #(
        .IMG_W(2), .IMG_H(2), .ADDR_W(2), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .filt_done(filt_done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (rst_n && !abort && tx_valid && tx_ready) begin
            log_q.push_back(tx_data);
            tlog.push_back(cyc);
        end
        if (rst_n && frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [7:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    task automatic pulse_start();
        log_q.delete();
        tlog.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 300), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] a, b,
                               c, d, cs);
        logic [7:0] exp [6];
        exp[0] = 8'hA5; exp[1] = a; exp[2] = b;
        exp[3] = c; exp[4] = d; exp[5] = cs;
        check({tag, "_nbytes"}, 32'(log_q.size()), 32'd6);
        if (log_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]),
                      32'(exp[i]));
        end
    endtask

    initial begin
        int n;
        int fd0;
        logic ok;
        logic [7:0] held;

        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        // Basic frame
        load_mem(8'd10, 8'd20, 8'd30, 8'd40);
        filt_done = 1'b1;
        tx_ready = 1'b1;
        fd0 = fd_cnt;
        pulse_start();
        wait_idle("f1");
        check_frame("f1", 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);
        check("f1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);
        if (tlog.size() >= 3)
            check("f1_pix_period", 32'(tlog[2] - tlog[1]), 32'd3);
        else
            check("f1_pix_period_nlog", 32'(tlog.size()), 32'd6);

        // Checksum wrap plus start pulsed while busy
        load_mem(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        fd0 = fd_cnt;
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle("f2");
        repeat (10) @(negedge clk);
        check_frame("f2", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        check("f2_no_second_frame", 32'(busy), 32'd0);
        check("f2_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // Backpressure during first pixel offer
        load_mem(8'd10, 8'd20, 8'd30, 8'd40);
        pulse_start();
        n = 0;
        while (!mem_rd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_rd_seen", 32'(mem_rd_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        held = tx_data;
        check("stall_held_pix", 32'(held), 32'd10);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === held &&
                  mem_rd_en === 1'b0))
                ok = 1'b0;
        end
        check("stall_stable", 32'(ok), 32'd1);
        tx_ready = 1'b1;
        wait_idle("f3");
        check_frame("f3", 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);

        // filt_done low: wait in WAIT_FILT, then drop it after SYNC
        filt_done = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        check("wf_busy", 32'(busy), 32'd1);
        check("wf_tx_valid", 32'(tx_valid), 32'd0);
        check("wf_no_bytes", 32'(log_q.size()), 32'd0);
        filt_done = 1'b1;
        @(negedge clk);
        check("wf_sync_offer", 32'(tx_data), 32'hA5);
        filt_done = 1'b0;
        wait_idle("f4");
        check_frame("f4", 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);
        filt_done = 1'b1;

        // Abort on the third pixel offer with tx_ready high
        fd0 = fd_cnt;
        pulse_start();
        n = 0;
        while (!(log_q.size() == 3 && tx_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ab_third_pix", 32'(tx_data), 32'd30);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_tx_valid", 32'(tx_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("ab_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("ab_nbytes", 32'(log_q.size()), 32'd3);
        pulse_start();
        wait_idle("f5");
        check_frame("f5", 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);

        // Asynchronous reset between edges mid-frame
        pulse_start();
        n = 0;
        while (!(log_q.size() == 2 && tx_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rr_pre_addr", 32'(mem_addr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_tx_valid", 32'(tx_valid), 32'd0);
        check("rr_tx_data", 32'(tx_data), 32'd0);
        check("rr_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rr_mem_addr", 32'(mem_addr), 32'd0);
        check("rr_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        fd0 = fd_cnt;
        pulse_start();
        wait_idle("f6");
        check_frame("f6", 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64);
        check("f6_frame_done", 32'(fd_cnt - fd0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
